// File: rtl/seq_fixed_point_mult_pkg.sv
// Shared types and width-derived constants for the sequential fixed-point multiplier.
package seq_fixed_point_mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StSign,
        StDone
    } state_e;

    // Counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    // Saturation limits, returned 64 bits wide; callers keep the low WIDTH bits.
    function automatic logic [63:0] max_pos(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] max_neg(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/seq_fixed_point_mult_saturate.sv
// Combinational fixed-point rescale: arithmetic shift by FRAC, then clamp to WIDTH bits.
module fixed_point_saturate
    import seq_fixed_point_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 0
) (
    input  logic signed [2*WIDTH-1:0] prod_in,
    output logic        [WIDTH-1:0]   sat_out,
    output logic                      overflow
);

    localparam logic [63:0] MaxPos = max_pos(WIDTH);
    localparam logic [63:0] MaxNeg = max_neg(WIDTH);

    logic signed [2*WIDTH-1:0] shifted;
    logic                      fits;

    // Value fits when every bit above the result sign bit equals the sign.
    always_comb begin
        shifted = prod_in >>> FRAC;
        fits    = (shifted[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){shifted[2*WIDTH-1]}});
        if (fits) begin
            sat_out  = shifted[WIDTH-1:0];
            overflow = 1'b0;
        end else begin
            sat_out  = shifted[2*WIDTH-1] ? MaxNeg[WIDTH-1:0] : MaxPos[WIDTH-1:0];
            overflow = 1'b1;
        end
    end

endmodule

// File: rtl/seq_fixed_point_mult.sv
// Multi-cycle signed radix-2 shift-add multiplier with saturated fixed-point result.
// Magnitudes are multiplied unsigned, sign applied once at the end. WIDTH must be >= 2.
module seq_fixed_point_mult
    import seq_fixed_point_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam int unsigned     W2      = 2 * WIDTH;
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic              sign_q, sign_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]     product_q, product_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    sum;
    logic [W2-1:0]     signed_acc;
    logic [WIDTH-1:0]  sat_result;
    logic              sat_ovf;

    fixed_point_saturate #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_saturate (
        .prod_in  (signed_acc),
        .sat_out  (sat_result),
        .overflow (sat_ovf)
    );

    // Datapath helpers: operand magnitudes, partial-product add, signed product.
    always_comb begin
        a_mag      = a[WIDTH-1] ? ('0 - a) : a;
        b_mag      = b[WIDTH-1] ? ('0 - b) : b;
        sum        = {1'b0, acc_q[W2-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        signed_acc = sign_q ? ('0 - acc_q) : acc_q;
    end

    // FSM next-state and register updates.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = CntInit;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                // Carry out of the add becomes the new MSB after the right shift.
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                product_d = signed_acc;
                result_d  = sat_result;
                ovf_d     = sat_ovf;
                state_d   = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            sign_q    <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign product   = product_q;
    assign result    = result_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_fixed_point_mult.sv
// Self-checking bench: two instances (FRAC=0 and FRAC=16) against a plain-arithmetic model.
module tb_seq_fixed_point_mult;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv[2];
    logic        ir[2];
    logic        ov[2];
    logic        ordy[2];
    logic        ovf[2];
    logic [31:0] av[2];
    logic [31:0] bv[2];
    logic [31:0] res[2];
    logic [63:0] prod[2];

    int          passed = 0;
    int          total = 0;
    longint      cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_fixed_point_mult #(.WIDTH(W), .FRAC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .product(prod[0]), .result(res[0]),
        .overflow(ovf[0])
    );

    seq_fixed_point_mult #(.WIDTH(W), .FRAC(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .product(prod[1]), .result(res[1]),
        .overflow(ovf[1])
    );

    // Reference: exact 64-bit signed product, arithmetic rescale, clamp to 32-bit range.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input int frac,
                                  output logic [63:0] p, output logic [31:0] r, output logic o);
        longint pr;
        longint sh;
        pr = longint'($signed(x)) * longint'($signed(y));
        sh = pr >>> frac;
        p  = pr;
        if (sh > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF;
            o = 1'b1;
        end else if (sh < -64'sd2147483648) begin
            r = 32'h8000_0000;
            o = 1'b1;
        end else begin
            r = sh[31:0];
            o = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] mag;
        if ($urandom_range(0, 1) == 0) return $urandom;
        mag = $urandom_range(0, 32'h0010_0000);
        return ($urandom_range(0, 1) == 1) ? (32'd0 - mag) : mag;
    endfunction

    // Submit one operation and wait for out_valid; lat = edges after accept, -1 on timeout.
    task automatic run_op(input int d, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic [63:0] p, output logic [31:0] r,
                          output logic o);
        int guard;
        @(negedge clk);
        iv[d] = 1'b1;
        av[d] = x;
        bv[d] = y;
        guard = 0;
        while (!ir[d] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!ov[d]) lat = -1;
        p = prod[d];
        r = res[d];
        o = ovf[d];
    endtask

    task automatic release_result(input int d);
        ordy[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({ir[d], ov[d], ovf[d], prod[d], res[d]} !== {1'b1, 1'b0, 1'b0, 64'd0, 32'd0})
                $display("FAIL reset_state[%0d]: got ir=%b ov=%b ovf=%b p=%h r=%h want 1 0 0 0 0",
                         d, ir[d], ov[d], ovf[d], prod[d], res[d]);
            else passed++;
        end
    endtask

    task automatic test_directed();
        int          dsel[4] = '{0, 0, 0, 1};
        logic [31:0] ta[4]   = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0001_8000};
        logic [31:0] tb[4]   = '{32'd5, 32'd6, 32'h8000_0000, 32'hFFFE_0000};
        logic [63:0] ep[4]   = '{64'd15, 64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000,
                                 64'hFFFF_FFFD_0000_0000};
        logic [31:0] er[4]   = '{32'd15, 32'hFFFF_FFD6, 32'h7FFF_FFFF, 32'hFFFD_0000};
        logic        eo[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
        int          lat;
        logic [63:0] p;
        logic [31:0] r;
        logic        o;
        for (int i = 0; i < 4; i++) begin
            run_op(dsel[i], ta[i], tb[i], lat, p, r, o);
            total++;
            if (lat !== W + 1) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W + 1);
            else passed++;
            total++;
            if ({p, r, o} !== {ep[i], er[i], eo[i]})
                $display("FAIL directed_result[%0d]: got p=%h r=%h o=%b want p=%h r=%h o=%b",
                         i, p, r, o, ep[i], er[i], eo[i]);
            else passed++;
            release_result(dsel[i]);
            total++;
            if ({ir[dsel[i]], ov[dsel[i]]} !== 2'b10)
                $display("FAIL directed_reopen[%0d]: got ir=%b ov=%b want 1 0",
                         i, ir[dsel[i]], ov[dsel[i]]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] x, y, r, er;
        logic [63:0] p, ep;
        logic        o, eo;
        for (int i = 0; i < 16; i++) begin
            int d = i % 2;
            x = rand_operand();
            y = rand_operand();
            model(x, y, d * 16, ep, er, eo);
            run_op(d, x, y, lat, p, r, o);
            total++;
            if (lat !== W + 1 || {p, r, o} !== {ep, er, eo})
                $display("FAIL random[%0d] a=%h b=%h: got lat=%0d p=%h r=%h o=%b want lat=%0d p=%h r=%h o=%b",
                         i, x, y, lat, p, r, o, W + 1, ep, er, eo);
            else passed++;
            release_result(d);
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [31:0] x, y, r, er;
        logic [63:0] p, ep;
        logic        o, eo;
        x = 32'h1234_5678;
        y = 32'hFFFF_0F0F;
        model(x, y, 0, ep, er, eo);
        ordy[0] = 1'b0;
        run_op(0, x, y, lat, p, r, o);
        total++;
        if ({p, r, o} !== {ep, er, eo})
            $display("FAIL bp_result: got p=%h r=%h o=%b want p=%h r=%h o=%b", p, r, o, ep, er, eo);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) begin
                iv[0] = 1'b1;
                av[0] = 32'd99;
                bv[0] = 32'd77;
            end
            if (i == 5) iv[0] = 1'b0;
            total++;
            if ({ov[0], ir[0], prod[0], res[0], ovf[0]} !== {1'b1, 1'b0, ep, er, eo})
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b p=%h r=%h o=%b want 1 0 %h %h %b",
                         i, ov[0], ir[0], prod[0], res[0], ovf[0], ep, er, eo);
            else passed++;
        end
        release_result(0);
        total++;
        if ({ir[0], ov[0]} !== 2'b10)
            $display("FAIL bp_release: got ir=%b ov=%b want 1 0", ir[0], ov[0]);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if ({ir[0], ov[0]} !== 2'b10)
            $display("FAIL bp_no_queue: got ir=%b ov=%b want 1 0", ir[0], ov[0]);
        else passed++;
    endtask

    task automatic test_reset_mid_calc();
        int          lat, guard;
        logic [31:0] x, y, r, er;
        logic [63:0] p, ep;
        logic        o, eo;
        @(negedge clk);
        iv[0] = 1'b1;
        av[0] = 32'h0000_BEEF;
        bv[0] = 32'h0000_1234;
        guard = 0;
        while (!ir[0] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({ir[0], ov[0], ovf[0], prod[0], res[0]} !== {1'b1, 1'b0, 1'b0, 64'd0, 32'd0})
            $display("FAIL reset_mid_calc: got ir=%b ov=%b ovf=%b p=%h r=%h want 1 0 0 0 0",
                     ir[0], ov[0], ovf[0], prod[0], res[0]);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ir[0], ov[0]} !== 2'b10)
            $display("FAIL reset_release: got ir=%b ov=%b want 1 0", ir[0], ov[0]);
        else passed++;
        x = 32'hFFFF_8001;
        y = 32'h0000_7FFF;
        model(x, y, 0, ep, er, eo);
        run_op(0, x, y, lat, p, r, o);
        total++;
        if (lat !== W + 1 || {p, r, o} !== {ep, er, eo})
            $display("FAIL reset_fresh_op: got lat=%0d p=%h r=%h o=%b want lat=%0d p=%h r=%h o=%b",
                     lat, p, r, o, W + 1, ep, er, eo);
        else passed++;
        release_result(0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] qp[$];
        logic [31:0] qr[$];
        logic        qo[$];
        longint      acc_cyc[3];
        int          nacc = 0;
        int          ndone = 0;
        logic [63:0] ep;
        logic [31:0] er;
        logic        eo;
        @(negedge clk);
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        av[0]   = rand_operand();
        bv[0]   = rand_operand();
        for (int t = 0; t < 300 && ndone < 3; t++) begin
            if (ov[0]) begin
                total++;
                if (qp.size() == 0) begin
                    $display("FAIL b2b_unexpected: got out_valid with no operation pending, want none");
                end else begin
                    ep = qp.pop_front();
                    er = qr.pop_front();
                    eo = qo.pop_front();
                    if ({prod[0], res[0], ovf[0]} !== {ep, er, eo})
                        $display("FAIL b2b_result[%0d]: got p=%h r=%h o=%b want p=%h r=%h o=%b",
                                 ndone, prod[0], res[0], ovf[0], ep, er, eo);
                    else passed++;
                end
                ndone++;
            end
            if (ir[0] && iv[0] && nacc < 3) begin
                model(av[0], bv[0], 0, ep, er, eo);
                qp.push_back(ep);
                qr.push_back(er);
                qo.push_back(eo);
                acc_cyc[nacc] = cyc;
                nacc++;
            end else if (!ir[0]) begin
                if (nacc < 3) begin
                    av[0] = rand_operand();
                    bv[0] = rand_operand();
                end else begin
                    iv[0] = 1'b0;
                end
            end
            @(negedge clk);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        total++;
        if (ndone !== 3) $display("FAIL b2b_count: got %0d results want 3", ndone);
        else passed++;
        for (int i = 1; i < 3; i++) begin
            total++;
            if (i >= nacc || acc_cyc[i] - acc_cyc[i-1] !== longint'(W + 3))
                $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d", i,
                         (i < nacc) ? acc_cyc[i] - acc_cyc[i-1] : -1, W + 3);
            else passed++;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
            av[d]   = '0;
            bv[d]   = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_fixed_point_mult.md
# seq_fixed_point_mult

Multi-cycle signed fixed-point multiplier: the inverse of the approximate divider path. Given a quotient and divisor, it reconstructs the dividend with an exact radix-2 shift-add multiplication. It sits beside the divider in the neuron arithmetic datapath. Operands are accepted and results returned over valid/ready handshakes, and it is used to re-scale fixed-point values and check divider results.

## Interface

Parameters:
- WIDTH, 32, operand and fixed-point result width (two's complement)
- FRAC, 0, fractional bits of operands and fixed-point result; legal range 0..WIDTH-1

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  signed multiplicand
- b  in  WIDTH  signed multiplier
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- product  out  2*WIDTH  full signed product a*b
- result  out  WIDTH  fixed-point product, saturated
- overflow  out  1  result saturated

## Operation

- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch |a| and |b| as WIDTH-bit unsigned magnitudes, latch sign = a[MSB]^b[MSB], clear the accumulator, load the bit counter with WIDTH, and go to CALC.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable unsigned.
- CALC:
  - One iteration per cycle: if multiplier LSB is 1, add the multiplicand magnitude to the upper half of the 2*WIDTH accumulator (WIDTH+1-bit add, carry kept), then shift the accumulator right 1 and the multiplier right 1.
  - Decrement the counter. After WIDTH iterations, go to SIGN.
- SIGN:
  - If sign=1, negate the accumulator (two's complement, 2*WIDTH bits).
  - Compute the fixed-point result: take shifted = product >>> FRAC (arithmetic).
  - If shifted lies within [-2^(WIDTH-1), 2^(WIDTH-1)-1], set result = shifted[WIDTH-1:0] and overflow=0.
  - Otherwise set result = 0x7F..F for positive or 0x80..0 for negative, with overflow=1.
  - Go to DONE.
- DONE:
  - out_valid=1. product, result and overflow are held stable.
  - On out_valid&out_ready, go to IDLE.
- in_ready is 0 in CALC, SIGN and DONE. in_valid there is ignored, with no queueing.
- A zero operand runs the full iteration count; there is no early exit.

## Timing

- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, result=0, overflow=0, counter=0.
- Reset asserted in any state aborts immediately and discards the operation. No stale out_valid after release.
- Latency: operands accepted at edge T → out_valid rises after edge T+WIDTH+1 (33 cycles for WIDTH=32).
- Throughput:
  - One operation per WIDTH+3 cycles with out_ready held high.
  - The DONE→IDLE edge re-opens in_ready, so the next accept is the following cycle.
  - in_ready is not combinationally tied to out_ready.
- Backpressure: DONE holds indefinitely while out_ready=0. Outputs must not change.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure

- Shared package holds:
  - the state enum (IDLE/CALC/SIGN/DONE)
  - the counter-width constant $clog2(WIDTH+1)
  - saturation constants MAX_POS/MAX_NEG derived from WIDTH
- One sub-module: fixed_point_saturate (combinational: 2*WIDTH signed in, FRAC shift, WIDTH-bit saturated out plus overflow). It is instantiated once and used in SIGN.
- Top holds the FSM, counter, accumulator, sign flag and output registers.

## Test plan

- FRAC=0, a=3, b=5 → out_valid at T+33; product=15, result=15, overflow=0.
- FRAC=0, a=-7, b=6 → product=-42 (0xFFFF_FFFF_FFFF_FFD6), result=0xFFFF_FFD6, overflow=0.
- FRAC=0, a=b=0x8000_0000 → product=0x4000_0000_0000_0000, result=0x7FFF_FFFF, overflow=1.
- FRAC=16, a=0x0001_8000 (1.5), b=0xFFFE_0000 (-2.0) → result=0xFFFD_0000 (-3.0), overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs and out_valid stable, in_ready=0. Then pulse in_valid mid-wait → ignored. Release → one handshake, in_ready=1 the next cycle.
- Reset pulse during CALC iteration 10 → all outputs at reset values, in_ready=1 after release. A fresh operation then completes with the correct product.
